// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state codes, bit-period floor
// and power-on configuration defaults.
package uart_rx_pkg;

    localparam int unsigned MIN_BP_DEFAULT = 2;
    localparam logic [13:0] DEF_BIT_PERIOD = 14'd10;
    localparam logic [3:0]  DEF_DATA_SIZE  = 4'd8;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 3'd0;
    localparam rx_state_t ST_START = 3'd1;
    localparam rx_state_t ST_DATA  = 3'd2;
    localparam rx_state_t ST_STOP  = 3'd3;
    localparam rx_state_t ST_LOAD  = 3'd4;

    // Only 5..8 data bits are meaningful; anything else falls back to a full byte.
    function automatic logic [3:0] clamp_size(input logic [3:0] size);
        return ((size >= 4'd5) && (size <= 4'd8)) ? size : 4'd8;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period down-counter; pulses sample for one cycle when the count reaches
// zero and reloads from period in the same cycle.
module rx_bit_timer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [13:0] period,
    output logic        sample
);

    logic [13:0] cnt;

    assign sample = enable && !clear && (cnt == 14'd0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= 14'd0;
        end else if (clear || sample) begin
            cnt <= period - 14'd1;
        end else if (enable) begin
            cnt <= cnt - 14'd1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: line synchronizer, frame FSM, LSB-first shift register and
// host-facing status flags. Timing comes from rx_bit_timer.
//
// state    | meaning
// IDLE     | waiting for a 1->0 edge on the synchronized line
// START    | half a bit in; confirm start bit is still low
// DATA     | sampling data bits once per bit period
// STOP     | sampling the stop bit
// LOAD     | one cycle: publish byte and update flags
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned MIN_BP = MIN_BP_DEFAULT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        serial_in,
    input  logic [13:0] bit_period,
    input  logic [3:0]  data_size,
    input  logic        data_read,
    output logic [7:0]  rx_data,
    output logic        data_ready,
    output logic        overrun_error,
    output logic        framing_error
);

    localparam logic [13:0] MIN_BP_W = 14'(MIN_BP);

    logic [1:0]  sync_q;
    logic        line;
    logic        line_prev;
    rx_state_t   state;
    logic [13:0] bp_lat;
    logic [3:0]  size_lat;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [13:0] bp_eff_in;
    logic [13:0] timer_period;
    logic        start_edge;
    logic        sample;
    logic [7:0]  load_val;

    assign line       = sync_q[1];
    assign bp_eff_in  = (bit_period < MIN_BP_W) ? MIN_BP_W : bit_period;
    assign start_edge = (state == ST_IDLE) && line_prev && !line;
    // The first reload (on the start edge) is the half-bit offset; every later reload is a full bit.
    assign timer_period = (state == ST_IDLE) ? (bp_eff_in >> 1) : bp_lat;
    assign load_val     = shreg >> (4'd8 - size_lat);

    rx_bit_timer u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (start_edge),
        .enable (state != ST_IDLE),
        .period (timer_period),
        .sample (sample)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], serial_in};
            line_prev <= line;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= ST_IDLE;
            bp_lat        <= DEF_BIT_PERIOD;
            size_lat      <= DEF_DATA_SIZE;
            bit_cnt       <= 4'd0;
            shreg         <= 8'h00;
            rx_data       <= 8'h00;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (state == ST_LOAD) begin
                rx_data       <= load_val;
                data_ready    <= 1'b1;
                framing_error <= 1'b0;
                if (data_ready && !data_read) begin
                    overrun_error <= 1'b1;
                end
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state    <= ST_START;
                        bp_lat   <= bp_eff_in;
                        size_lat <= clamp_size(data_size);
                        bit_cnt  <= 4'd0;
                        shreg    <= 8'h00;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        state <= line ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shreg   <= {line, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == size_lat - 4'd1) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        if (line) begin
                            state <= ST_LOAD;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= ST_IDLE;
                        end
                    end
                end
                ST_LOAD: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames driven bit by bit on serial_in with
// hand-computed expected bytes, flags and latency.
module tb_uart_rx_core;
    import uart_rx_pkg::*;

    localparam int BP = 10;

    logic        clk;
    logic        n_rst;
    logic        serial_in;
    logic [13:0] bit_period;
    logic [3:0]  data_size;
    logic        data_read;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        overrun_error;
    logic        framing_error;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    uart_rx_core dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .bit_period    (bit_period),
        .data_size     (data_size),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each bit is held for BP clocks, changing on falling edges.
    task automatic send_frame(input logic [7:0] d, input int n, input logic stop);
        @(negedge clk);
        serial_in = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            serial_in = d[i];
            repeat (BP) @(negedge clk);
        end
        serial_in = stop;
        repeat (BP) @(negedge clk);
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst      = 1'b0;
        serial_in  = 1'b1;
        data_read  = 1'b0;
        bit_period = DEF_BIT_PERIOD;
        data_size  = DEF_DATA_SIZE;
        repeat (3) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_ready", 32'(data_ready), 0);
        check("rst_overrun", 32'(overrun_error), 0);
        check("rst_framing", 32'(framing_error), 0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5, 8 bits; data_ready expected 2 sync + 5 + 9*10 + 1 = 98 edges after the start bit is driven
        lat = -1;
        fork
            send_frame(8'hA5, 8, 1'b1);
            begin
                @(negedge clk);
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk);
                    #1;
                    if (data_ready) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        check("a5_latency", 32'(lat), 98);
        check("a5_ready", 32'(data_ready), 1);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_overrun", 32'(overrun_error), 0);
        check("a5_framing", 32'(framing_error), 0);
        pulse_read();
        check("a5_read_ready", 32'(data_ready), 0);

        // 5-bit frame, right-justified
        data_size = 4'd5;
        send_frame(8'h1B, 5, 1'b1);
        check("s5_data", 32'(rx_data), 32'h1B);
        check("s5_upper", 32'(rx_data[7:5]), 0);
        check("s5_ready", 32'(data_ready), 1);
        pulse_read();
        check("s5_read_ready", 32'(data_ready), 0);

        // bad stop bit keeps old byte
        data_size = 4'd8;
        send_frame(8'h3C, 8, 1'b0);
        check("fe_framing", 32'(framing_error), 1);
        check("fe_ready", 32'(data_ready), 0);
        check("fe_data", 32'(rx_data), 32'h1B);

        // data_size 0 falls back to 8 bits; good frame clears framing_error
        data_size = 4'd0;
        send_frame(8'h11, 8, 1'b1);
        check("ok_framing", 32'(framing_error), 0);
        check("ok_data", 32'(rx_data), 32'h11);
        check("ok_ready", 32'(data_ready), 1);
        pulse_read();
        data_size = 4'd8;

        // config changes after the start edge must not disturb the frame
        fork
            send_frame(8'h55, 8, 1'b1);
            begin
                repeat (30) @(negedge clk);
                bit_period = 14'd3;
                data_size  = 4'd5;
            end
        join
        bit_period = DEF_BIT_PERIOD;
        data_size  = DEF_DATA_SIZE;
        check("ov1_data", 32'(rx_data), 32'h55);
        check("ov1_overrun", 32'(overrun_error), 0);
        send_frame(8'hAA, 8, 1'b1);
        check("ov2_overrun", 32'(overrun_error), 1);
        check("ov2_data", 32'(rx_data), 32'hAA);
        check("ov2_ready", 32'(data_ready), 1);
        pulse_read();
        check("ov_read_ready", 32'(data_ready), 0);
        check("ov_read_overrun", 32'(overrun_error), 0);

        // 3-clock low glitch is rejected at the start-bit check
        @(negedge clk);
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (30) @(negedge clk);
        check("gl_ready", 32'(data_ready), 0);
        check("gl_framing", 32'(framing_error), 0);
        check("gl_overrun", 32'(overrun_error), 0);
        check("gl_data", 32'(rx_data), 32'hAA);

        // reset during a frame, released once the line is idle again
        fork
            send_frame(8'h5A, 8, 1'b1);
            begin
                repeat (40) @(negedge clk);
                n_rst = 1'b0;
                repeat (2) @(negedge clk);
                check("mr_in_rst_data", 32'(rx_data), 32'h00);
                repeat (63) @(negedge clk);
                n_rst = 1'b1;
            end
        join
        repeat (BP * 12) @(negedge clk);
        check("mr_data", 32'(rx_data), 32'h00);
        check("mr_ready", 32'(data_ready), 0);
        check("mr_overrun", 32'(overrun_error), 0);
        check("mr_framing", 32'(framing_error), 0);

        send_frame(8'h96, 8, 1'b1);
        check("post_rst_data", 32'(rx_data), 32'h96);
        check("post_rst_ready", 32'(data_ready), 1);
        check("post_rst_overrun", 32'(overrun_error), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
